pi_err_gen: RTL and testbench

PI_ERR_GEN -- requirements
Module: pi_err_gen

---
 rtl/pi_err_gen_if.sv | 28 ++
 rtl/pi_err_gen.sv | 112 +++++++++++
 tb/tb_pi_err_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pi_err_gen_if.sv
// rtl/pi_err_gen_if.sv - sample/PI handshake bundle for pi_err_gen
interface pi_err_gen_if #(
  parameter int DW = 32
);
  logic          sample_tick;
  logic [DW-1:0] ref_in;
  logic [DW-1:0] fb_in;
  logic          pi_done;
  logic [63:0]   pi_result;
  logic          flag_clr;
  logic [DW-1:0] ek;
  logic [DW-1:0] ek_ex;
  logic [DW-1:0] uk_ex;
  logic          pista;
  logic          busy;
  logic          overrun;
  logic          timeout;

  modport master (
    output sample_tick, ref_in, fb_in, pi_done, pi_result, flag_clr,
    input  ek, ek_ex, uk_ex, pista, busy, overrun, timeout
  );

  modport slave (
    input  sample_tick, ref_in, fb_in, pi_done, pi_result, flag_clr,
    output ek, ek_ex, uk_ex, pista, busy, overrun, timeout
  );
endinterface

// File: rtl/pi_err_gen.sv
// rtl/pi_err_gen.sv - PI error generator; optional deadband via PI_ERR_DEADBAND_EN
module pi_err_gen #(
  parameter int DW       = 32,
  parameter int WAIT_MAX = 64,
  parameter int DEADBAND = 4
) (
  input logic           clk,
  input logic           rst_n,
  pi_err_gen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, START, WAIT} state_t;

  localparam int            CW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] ref_q;
  logic [DW-1:0] fb_q;
  logic [DW:0]   diff;
  logic [DW-1:0] sat;
  logic [DW-1:0] ek_next;

  // Only the low DW bits of the PI result carry the clamped uk
  logic unused_res;
  assign unused_res = ^bus.pi_result[63:DW];

`ifdef PI_ERR_DEADBAND_EN
  localparam logic signed [DW:0] DB_POS = (DW+1)'(DEADBAND);
  localparam logic signed [DW:0] DB_NEG = -((DW+1)'(DEADBAND));
  logic signed [DW:0] sat_x;
`else
  localparam int unused_deadband = DEADBAND;
`endif

  // Error of the registered sample: one extra bit of headroom, then clamp to DW
  always_comb begin
    diff    = {ref_q[DW-1], ref_q} - {fb_q[DW-1], fb_q};
    if (diff[DW] != diff[DW-1])
      sat = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sat = diff[DW-1:0];
    ek_next = sat;
`ifdef PI_ERR_DEADBAND_EN
    sat_x = {sat[DW-1], sat};
    if ((sat_x <= DB_POS) && (sat_x >= DB_NEG))
      ek_next = '0;
`endif
  end

  // Sample/PI sequencing FSM with registered outputs and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ref_q         <= '0;
      fb_q          <= '0;
      bus.ek        <= '0;
      bus.ek_ex     <= '0;
      bus.uk_ex     <= '0;
      bus.pista     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      bus.pista <= 1'b0;
      // Clear first so that a same-cycle set below takes precedence
      if (bus.flag_clr) begin
        bus.overrun <= 1'b0;
        bus.timeout <= 1'b0;
      end
      if (bus.sample_tick && (state != IDLE))
        bus.overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.sample_tick) begin
            ref_q    <= bus.ref_in;
            fb_q     <= bus.fb_in;
            bus.busy <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          bus.ek_ex <= bus.ek;
          bus.ek    <= ek_next;
          bus.pista <= 1'b1;
          state     <= START;
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.pi_done) begin
            bus.uk_ex <= bus.pi_result[DW-1:0];
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end else if (cnt == CNT_LAST) begin
            bus.timeout <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_err_gen.sv
// tb/tb_pi_err_gen.sv - self-checking bench for pi_err_gen
module tb_pi_err_gen;
  localparam int DW       = 32;
  localparam int WAIT_MAX = 16;
  localparam int DEADBAND = 4;
`ifdef PI_ERR_DEADBAND_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  logic [DW-1:0] m_ek, m_ek_ex, m_uk_ex;
  bit            m_overrun, m_timeout;

  pi_err_gen_if #(.DW(DW)) bus ();

  pi_err_gen #(.DW(DW), .WAIT_MAX(WAIT_MAX), .DEADBAND(DEADBAND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] f;
    int            done_at;
    logic [63:0]   res;
    logic [DW-1:0] ek;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_err(input logic [DW-1:0] r, input logic [DW-1:0] f);
    longint d;
    longint maxv;
    longint minv;
    maxv = (longint'(1) <<< (DW-1)) - 1;
    minv = -(longint'(1) <<< (DW-1));
    d = longint'($signed(r)) - longint'($signed(f));
    if (d > maxv) d = maxv;
    if (d < minv) d = minv;
    if (DB_ON && d >= -DEADBAND && d <= DEADBAND) d = 0;
    return d[DW-1:0];
  endfunction

  task automatic set_extra(input int cyc, input int xt, input bit xc, input logic [DW-1:0] r);
    bus.sample_tick = (cyc == xt);
    bus.flag_clr    = (cyc == xt) && xc;
    bus.ref_in      = ~r;
    if (cyc == xt) begin
      if (xc) begin
        m_overrun = 1'b0;
        m_timeout = 1'b0;
      end
      m_overrun = 1'b1;
    end
  endtask

  // One full sample: tick in cycle 0, optional stray tick (and clear) at cycle xt
  task automatic do_txn(input logic [DW-1:0] r, input logic [DW-1:0] f, input int done_at,
                        input logic [63:0] res, input logic [DW-1:0] exp_ek,
                        input int xt, input bit xc);
    logic [DW-1:0] exp_ek_ex;
    bit done;
    exp_ek_ex = m_ek;
    bus.sample_tick = 1'b1;
    bus.ref_in = r;
    bus.fb_in  = f;
    @(negedge clk);
    chk("calc_busy", bus.busy, 1'b1);
    chk("calc_pista", bus.pista, 1'b0);
    set_extra(1, xt, xc, r);
    @(negedge clk);
    chk("start_pista", bus.pista, 1'b1);
    chk("start_busy", bus.busy, 1'b1);
    chk("start_ek", bus.ek, exp_ek);
    chk("start_ek_ex", bus.ek_ex, exp_ek_ex);
    chk("start_uk_ex", bus.uk_ex, m_uk_ex);
    set_extra(2, xt, xc, r);
    done = 1'b0;
    for (int w = 0; w < WAIT_MAX && !done; w++) begin
      @(negedge clk);
      chk("wait_pista", bus.pista, 1'b0);
      chk("wait_busy", bus.busy, 1'b1);
      chk("wait_timeout", bus.timeout, m_timeout);
      chk("wait_ek", bus.ek, exp_ek);
      set_extra(3 + w, xt, xc, r);
      if (w == done_at) begin
        bus.pi_done   = 1'b1;
        bus.pi_result = res;
        done = 1'b1;
      end
    end
    @(negedge clk);
    bus.pi_done = 1'b0;
    bus.sample_tick = 1'b0;
    bus.flag_clr = 1'b0;
    if (done) m_uk_ex = res[DW-1:0];
    else      m_timeout = 1'b1;
    m_ek_ex = exp_ek_ex;
    m_ek    = exp_ek;
    chk("end_busy", bus.busy, 1'b0);
    chk("end_pista", bus.pista, 1'b0);
    chk("end_uk_ex", bus.uk_ex, m_uk_ex);
    chk("end_timeout", bus.timeout, m_timeout);
    chk("end_overrun", bus.overrun, m_overrun);
    chk("end_ek", bus.ek, m_ek);
    chk("end_ek_ex", bus.ek_ex, m_ek_ex);
  endtask

  task automatic clr_flags();
    bus.flag_clr = 1'b1;
    m_overrun = 1'b0;
    m_timeout = 1'b0;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    chk("clr_overrun", bus.overrun, 1'b0);
    chk("clr_timeout", bus.timeout, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_pista", bus.pista, 1'b0);
      chk("idle_busy", bus.busy, 1'b0);
    end
  endtask

  vec_t tbl[8];

  initial begin
    logic [DW-1:0] r, f;
    int            da;
    n_vec = 0;
    n_bad = 0;
    m_ek = '0; m_ek_ex = '0; m_uk_ex = '0; m_overrun = 1'b0; m_timeout = 1'b0;

    tbl[0] = '{32'h0000_0100, 32'h0000_0040, 5,            64'h0000_0000_0000_1234, 32'h0000_00C0};
    tbl[1] = '{32'h0000_0040, 32'h0000_0100, 0,            64'hABCD_0000_0000_5678, 32'hFFFF_FF40};
    tbl[2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, WAIT_MAX - 1, 64'h1,                   32'h7FFF_FFFF};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 3,            64'h2,                   32'h8000_0000};
    tbl[4] = '{32'h0000_0003, 32'h0000_0000, 1,            64'h3,                   DB_ON ? 32'h0 : 32'h3};
    tbl[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 2,            64'h4,                   DB_ON ? 32'h0 : 32'hFFFF_FFFC};
    tbl[6] = '{32'h0000_0005, 32'h0000_0000, 2,            64'h5,                   32'h0000_0005};
    tbl[7] = '{32'h0000_0000, 32'h0000_0000, WAIT_MAX,     64'h99,                  32'h0};

    rst_n = 1'b0;
    bus.sample_tick = 1'b0; bus.ref_in = '0; bus.fb_in = '0;
    bus.pi_done = 1'b0; bus.pi_result = '0; bus.flag_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ek", bus.ek, 0);
    chk("rst_ek_ex", bus.ek_ex, 0);
    chk("rst_uk_ex", bus.uk_ex, 0);
    chk("rst_pista", bus.pista, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_timeout", bus.timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      do_txn(tbl[i].r, tbl[i].f, tbl[i].done_at, tbl[i].res, tbl[i].ek, -1, 1'b0);
    clr_flags();

    // Stray tick in START: dropped, overrun raised, single pista, first sample kept
    do_txn(32'h200, 32'h100, 4, 64'h77, 32'h100, 2, 1'b0);
    idle_cycles(4);
    // Stray tick coinciding with pi_done: result still taken
    do_txn(32'h300, 32'h100, 1, 64'h88, 32'h200, 4, 1'b0);
    clr_flags();
    // Clear and overrun in the same cycle: overrun wins
    do_txn(32'h10, 32'h20, 2, 64'h9, 32'hFFFF_FFF0, 1, 1'b1);
    clr_flags();

    // pi_done while idle is ignored
    bus.pi_done = 1'b1;
    bus.pi_result = 64'hDEAD;
    @(negedge clk);
    bus.pi_done = 1'b0;
    chk("idle_done_uk_ex", bus.uk_ex, m_uk_ex);
    chk("idle_done_busy", bus.busy, 1'b0);

    // Reset in the middle of WAIT aborts and zeroes the history
    bus.sample_tick = 1'b1; bus.ref_in = 32'h55; bus.fb_in = 32'h11;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ek", bus.ek, 0);
    chk("midrst_ek_ex", bus.ek_ex, 0);
    chk("midrst_uk_ex", bus.uk_ex, 0);
    chk("midrst_pista", bus.pista, 0);
    rst_n = 1'b1;
    m_ek = '0; m_ek_ex = '0; m_uk_ex = '0; m_overrun = 1'b0; m_timeout = 1'b0;
    @(negedge clk);
    do_txn(32'h10, 32'h4, 2, 64'h21, 32'hC, -1, 1'b0);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = DW'($urandom_range(0, 20)) - DW'(10);
        f = DW'($urandom_range(0, 20)) - DW'(10);
      end else begin
        r = $urandom;
        f = $urandom;
      end
      da = $urandom_range(0, WAIT_MAX + 2);
      if ($urandom_range(0, 4) == 0)
        do_txn(r, f, da, {$urandom, $urandom}, ref_err(r, f),
               $urandom_range(1, 5), 1'($urandom_range(0, 1)));
      else
        do_txn(r, f, da, {$urandom, $urandom}, ref_err(r, f), -1, 1'b0);
      if ($urandom_range(0, 5) == 0)
        clr_flags();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
